// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a single shared combinational ALU.
// One operation is outstanding at a time: IDLE accepts a request,
// EXEC captures the ALU result, and RESP holds it until the requester takes it.
// Define ALU_ARB_FIXED_PRIO_EN to give port 0 fixed priority instead of round-robin.
module alu_arbiter #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [3:0]    req0_op,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic          req0_cin,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [3:0]    req1_op,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic          req1_cin,
  output logic          resp0_valid,
  input  logic          resp0_ready,
  output logic          resp1_valid,
  input  logic          resp1_ready,
  output logic [DW-1:0] resp_c,
  output logic          resp_cout,
  output logic [3:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic          alu_cin,
  input  logic [DW-1:0] alu_c,
  input  logic          alu_cout,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;
  logic          gnt;
  logic          grant_id;
  logic          handshake;
  logic          resp_fire;
  logic [3:0]    op_r;
  logic [DW-1:0] a_r;
  logic [DW-1:0] b_r;
  logic          cin_r;
  logic [DW-1:0] c_r;
  logic          cout_r;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Port 0 wins whenever it is valid; otherwise port 1 is the candidate.
  always_comb begin
    gnt = 1'b0;
    if (!req0_valid) gnt = 1'b1;
  end
`else
  logic last_served;

  // Round-robin: on contention serve the port that did not go last.
  always_comb begin
    gnt = req1_valid;
    if (req0_valid && req1_valid) gnt = ~last_served;
  end

  // Remember who was served once its response has been taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_served <= 1'b1;
    end else if (resp_fire) begin
      last_served <= grant_id;
    end
  end
`endif

  assign req0_ready = (state == IDLE) && req0_valid && !gnt;
  assign req1_ready = (state == IDLE) && req1_valid && gnt;
  assign handshake  = req0_ready || req1_ready;
  assign resp_fire  = (state == RESP) && (grant_id ? resp1_ready : resp0_ready);

  // State register; reset drops any outstanding operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic for the single-outstanding-operation sequence.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (handshake) next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    if (resp_fire) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand capture on handshake and result capture in EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_id <= 1'b0;
      op_r     <= '0;
      a_r      <= '0;
      b_r      <= '0;
      cin_r    <= 1'b0;
      c_r      <= '0;
      cout_r   <= 1'b0;
    end else begin
      if (handshake) begin
        grant_id <= gnt;
        op_r     <= gnt ? req1_op  : req0_op;
        a_r      <= gnt ? req1_a   : req0_a;
        b_r      <= gnt ? req1_b   : req0_b;
        cin_r    <= gnt ? req1_cin : req0_cin;
      end
      if (state == EXEC) begin
        c_r    <= alu_c;
        cout_r <= alu_cout;
      end
    end
  end

  assign alu_op      = op_r;
  assign alu_a       = a_r;
  assign alu_b       = b_r;
  assign alu_cin     = cin_r;
  assign resp_c      = c_r;
  assign resp_cout   = cout_r;
  assign resp0_valid = (state == RESP) && !grant_id;
  assign resp1_valid = (state == RESP) && grant_id;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by
// randomized traffic compared against a transaction-level reference model.
module tb_alu_arbiter;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [3:0]    req0_op, req1_op;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic          req0_cin, req1_cin;
  logic          resp0_valid, resp1_valid;
  logic          resp0_ready, resp1_ready;
  logic [DW-1:0] resp_c;
  logic          resp_cout;
  logic [3:0]    alu_op;
  logic [DW-1:0] alu_a, alu_b, alu_c;
  logic          alu_cin, alu_cout;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int last_srv = 1;
  logic [3:0]    op_q  [2];
  logic [DW-1:0] a_q   [2];
  logic [DW-1:0] b_q   [2];
  logic          cin_q [2];
  bit            pend  [2];

  alu_arbiter #(.DW(DW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_c(resp_c), .resp_cout(resp_cout),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_c(alu_c), .alu_cout(alu_cout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Opcode set of the shared ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 LHI, rest arbitrary.
  function automatic logic [DW:0] alu_ref(input logic [3:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b, input logic cin);
    logic [DW:0] r;
    case (op)
      4'd0:    r = {1'b0, a} + {1'b0, b} + 17'(cin);
      4'd1:    r = {1'b0, a} - {1'b0, b} - 17'(cin);
      4'd2:    r = {1'b0, a & b};
      4'd3:    r = {1'b0, a | b};
      4'd4:    r = {1'b0, a ^ b};
      4'd5:    r = {1'b0, b[7:0], 8'h00};
      default: r = {cin ^ a[0], {a[7:0], b[15:8]} ^ {12'h000, op}};
    endcase
    return r;
  endfunction

  // Behavioural ALU sitting behind the arbiter.
  always_comb {alu_cout, alu_c} = alu_ref(alu_op, alu_a, alu_b, alu_cin);

  function automatic int predictGrant();
`ifdef ALU_ARB_FIXED_PRIO_EN
    return req0_valid ? 0 : 1;
`else
    if (req0_valid && req1_valid) return 1 - last_srv;
    return req1_valid ? 1 : 0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int p, input bit v, input logic [3:0] op,
                               input logic [DW-1:0] a, input logic [DW-1:0] b, input logic cin);
    op_q[p] = op; a_q[p] = a; b_q[p] = b; cin_q[p] = cin;
    if (p == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_cin = cin;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_cin = cin;
    end
  endtask

  task automatic checkIdleAfterReset(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'(0));
    checkOutput({tag, "_resp_valid"}, 32'({resp1_valid, resp0_valid}), 32'(0));
    checkOutput({tag, "_alu_a"}, 32'(alu_a), 32'(0));
    checkOutput({tag, "_alu_op"}, 32'(alu_op), 32'(0));
    checkOutput({tag, "_resp_c"}, 32'(resp_c), 32'(0));
  endtask

  // One complete transaction: grant, EXEC, RESP with optional hold and stray readies.
  task automatic runOne(input int resp_delay, input bit stray, output int g);
    logic [DW:0] exp_r;
    g = predictGrant();
    exp_r = alu_ref(op_q[g], a_q[g], b_q[g], cin_q[g]);
    #1;
    checkOutput("req0_ready_idle", 32'(req0_ready), 32'(g == 0));
    checkOutput("req1_ready_idle", 32'(req1_ready), 32'(g == 1));
    checkOutput("busy_idle", 32'(busy), 32'(0));
    step();
    checkOutput("busy_exec", 32'(busy), 32'(1));
    checkOutput("resp_valid_exec", 32'({resp1_valid, resp0_valid}), 32'(0));
    checkOutput("req_ready_exec", 32'({req1_ready, req0_ready}), 32'(0));
    checkOutput("alu_op", 32'(alu_op), 32'(op_q[g]));
    checkOutput("alu_a", 32'(alu_a), 32'(a_q[g]));
    checkOutput("alu_b", 32'(alu_b), 32'(b_q[g]));
    checkOutput("alu_cin", 32'(alu_cin), 32'(cin_q[g]));
    if (stray) begin
      if (g == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
    end
    step();
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    checkOutput("resp0_valid", 32'(resp0_valid), 32'(g == 0));
    checkOutput("resp1_valid", 32'(resp1_valid), 32'(g == 1));
    checkOutput("resp_c", 32'(resp_c), 32'(exp_r[DW-1:0]));
    checkOutput("resp_cout", 32'(resp_cout), 32'(exp_r[DW]));
    for (int i = 0; i < resp_delay; i++) begin
      if (stray) begin
        if (g == 0) resp1_ready = 1'b1; else resp0_ready = 1'b1;
      end
      step();
      resp0_ready = 1'b0; resp1_ready = 1'b0;
      checkOutput("hold_resp_valid", 32'({resp1_valid, resp0_valid}), 32'(g == 1 ? 2 : 1));
      checkOutput("hold_resp_c", 32'(resp_c), 32'(exp_r[DW-1:0]));
      checkOutput("hold_busy", 32'(busy), 32'(1));
      checkOutput("hold_req_ready", 32'({req1_ready, req0_ready}), 32'(0));
      checkOutput("hold_alu_a", 32'(alu_a), 32'(a_q[g]));
    end
    if (g == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
    step();
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    checkOutput("busy_after_resp", 32'(busy), 32'(0));
    checkOutput("resp_valid_after_resp", 32'({resp1_valid, resp0_valid}), 32'(0));
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_srv = g;
`endif
  endtask

  initial begin
    int g;
    reset = 1'b1;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    applyStimulus(0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0);
    applyStimulus(1, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0);
    step();
    step();
    reset = 1'b0;
    last_srv = 1;
    checkIdleAfterReset("reset");
    checkOutput("reset_req_ready", 32'({req1_ready, req0_ready}), 32'(0));
    checkOutput("reset_alu_b", 32'(alu_b), 32'(0));
    checkOutput("reset_cout", 32'({alu_cin, resp_cout}), 32'(0));

    $display("[TB] add with carry out on port 0");
    applyStimulus(0, 1'b1, 4'd0, 16'hFFFF, 16'h0001, 1'b0);
    runOne(0, 1'b0, g);
    req0_valid = 1'b0;

    $display("[TB] subtract on port 1 with response held off");
    applyStimulus(1, 1'b1, 4'd1, 16'h0005, 16'h0003, 1'b1);
    runOne(4, 1'b0, g);
    req1_valid = 1'b0;

    $display("[TB] load-high on port 0 with stray and early readies");
    applyStimulus(0, 1'b1, 4'd5, 16'h1234, 16'h00AB, 1'b0);
    runOne(2, 1'b1, g);
    req0_valid = 1'b0;

    $display("[TB] continuous contention");
    applyStimulus(0, 1'b1, 4'd2, 16'hF0F0, 16'h3C3C, 1'b0);
    applyStimulus(1, 1'b1, 4'd3, 16'h0F00, 16'h00F0, 1'b1);
    for (int i = 0; i < 4; i++) runOne(0, 1'b0, g);

    $display("[TB] reset wins over a simultaneous handshake");
    applyStimulus(0, 1'b1, 4'd4, 16'hA5A5, 16'h5A5A, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    last_srv = 1;
    checkIdleAfterReset("reset_hs");
    req0_valid = 1'b0; req1_valid = 1'b0;

    $display("[TB] reset during EXEC");
    applyStimulus(0, 1'b1, 4'd0, 16'h1234, 16'h1111, 1'b0);
    step();
    checkOutput("exec_busy_pre_reset", 32'(busy), 32'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    last_srv = 1;
    checkIdleAfterReset("reset_exec");
    applyStimulus(0, 1'b1, 4'd0, 16'h0102, 16'h0304, 1'b1);
    runOne(1, 1'b0, g);
    req0_valid = 1'b0;

    $display("[TB] randomized traffic");
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int t = 0; t < 40; t++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p])
          applyStimulus(p, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                        16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      end
      if (!req0_valid && !req1_valid)
        applyStimulus($urandom_range(0, 1), 1'b1, 4'($urandom_range(0, 15)),
                      16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      runOne($urandom_range(0, 3), 1'($urandom_range(0, 1)), g);
      pend[g] = 1'b0;
      pend[1 - g] = (g == 0) ? req1_valid : req0_valid;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DW, default 16: datapath width of operands and result.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1 each: requester n presents an operation.
REQ-005 SHALL have ports req0_ready / req1_ready, output, 1 each: arbiter accepts requester n this cycle.
REQ-006 SHALL have ports reqN_op, input, 4; reqN_a, input, DW; reqN_b, input, DW; reqN_cin, input, 1, for N = 0 and 1: the operation fields.
REQ-007 SHALL have ports resp0_valid / resp1_valid, output, 1: result ready for requester n.
REQ-008 SHALL have ports resp0_ready / resp1_ready, input, 1: requester n consumes its result.
REQ-009 SHALL have ports resp_c, output, DW, and resp_cout, output, 1: shared result bus, meaningful only while a respN_valid is high.
REQ-010 SHALL have ports alu_op, output, 4; alu_a, output, DW; alu_b, output, DW; alu_cin, output, 1: drive the shared ALU.
REQ-011 SHALL have ports alu_c, input, DW, and alu_cout, input, 1: the ALU's combinational result.
REQ-012 SHALL have port busy, output, 1: high in every state other than IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, EXEC, and RESP, with exactly one operation outstanding.
REQ-014 In IDLE, SHALL raise reqN_ready combinationally only for the granted port, and only while that port's reqN_valid is high; it SHALL hold both readies low in EXEC and RESP.
REQ-015 SHALL arbitrate round-robin: when only one port is valid, grant that port; when both are valid, grant the port not recorded in last_served.
REQ-016 On a handshake (valid and ready high at an edge), SHALL register op, a, b, cin, and the grant id, then move IDLE->EXEC.
REQ-017 SHALL drive alu_op, alu_a, alu_b, and alu_cin from the operand registers only, never combinationally from the request ports.
REQ-018 In EXEC, SHALL capture alu_c and alu_cout into the result registers at the next edge, then move EXEC->RESP.
REQ-019 In RESP, SHALL assert respN_valid for the granted port only and hold resp_c and resp_cout stable until respN_ready is high at an edge.
REQ-020 On response acceptance, SHALL update last_served to the granted id and move RESP->IDLE.
REQ-021 Latency SHALL be: request handshake at edge T, respN_valid high from T+2; minimum issue interval is 3 cycles.
REQ-022 SHALL pass opcodes, including unassigned encodings, to the ALU unmodified and return whatever the ALU produces.
REQ-023 A request that arrives while busy SHALL be held by the requester, who SHALL keep its fields stable, and SHALL be considered in the next IDLE cycle.
REQ-024 In RESP, a respN_ready on the non-granted port SHALL be ignored.
REQ-025 A respN_ready asserted before respN_valid SHALL have no effect.

Reset
REQ-026 reset high at an edge SHALL force state IDLE and last_served=1, so port 0 wins the first contention.
REQ-027 reset high at an edge SHALL clear all operand and result registers to 0, so that alu_op, alu_a, alu_b, alu_cin, resp_c, and resp_cout read 0.
REQ-028 reset high at an edge SHALL drive both respN_valid low and busy low.
REQ-029 reset asserted in EXEC or RESP SHALL abort the operation with no response; the outstanding result is discarded.
REQ-030 reset SHALL take priority over every handshake occurring in the same cycle.

Configuration
REQ-031 Macro ALU_ARB_FIXED_PRIO_EN, when defined, SHALL make port 0 always win contention; last_served is then neither updated nor used.
REQ-032 Without ALU_ARB_FIXED_PRIO_EN, SHALL use the round-robin policy of REQ-015.

Verification
REQ-033 Port 0 issues OP_ADD, A=16'hFFFF, B=16'h0001, cin=0 -> resp0_valid at T+2 with resp_c=16'h0000 and resp_cout=1; resp1_valid stays 0.
REQ-034 Both ports valid continuously after reset, port 0 issuing OP_AND, port 1 issuing OP_OR -> grants 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN -> grants 0,0,0,0.
REQ-035 Port 1 issues OP_SUB, A=16'h0005, B=16'h0003, cin=1, with resp1_ready held low 4 cycles -> resp_c=16'h0001 held stable, busy=1, both readies 0 throughout.
REQ-036 Port 0 issues OP_LHI, B=16'h00AB -> resp_c=16'hAB00 and resp_cout=0; alu_* outputs stay constant during EXEC and RESP.
REQ-037 reset pulsed during EXEC -> next cycle state IDLE, resp0_valid=0 and resp1_valid=0, alu_a=0; a new port 0 request completes normally afterwards.
REQ-038 In RESP, resp1_ready pulsed while port 0 is granted -> no state change; the later resp0_ready returns the FSM to IDLE.
